// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, round functions and stage FSM encoding
//
// Purpose:
//   Common definitions for the double-SHA256 pipeline. The round stages use
//   K, the big Sigma functions, Ch and Maj; the W-memory stages use the small
//   sigma functions. IV is the standard initial hash value.
// Contents:
//   stage_state_t  IDLE / RUN / DONE encoding for iterative stages
//   IV             {H0..H7}, H0 at [255:224]
//   K              round constants K[0..63]
//   rotr, big_sigma0, big_sigma1, small_sigma0, small_sigma1, ch, maj

package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stage_state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right; n is always a constant in [1,31] at every call site.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// rtl/sha256_round_comb.sv - one combinational SHA-256 compression round
//
// Purpose:
//   Pure combinational single round: (a..h, W, K) -> next a..h.
// Ports:
//   cur  in  256  working state {a,b,c,d,e,f,g,h}, a at [255:224]
//   w    in  32   message schedule word for this round
//   k    in  32   round constant for this round
//   nxt  out 256  working state after the round, same packing as cur

module sha256_round_comb
  import sha256_pkg::*;
(
  input  logic [255:0] cur,
  input  logic [31:0]  w,
  input  logic [31:0]  k,
  output logic [255:0] nxt
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = cur;

  // All additions wrap mod 2^32 because the operands and results are 32 bits.
  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_round_stage_iter.sv
// rtl/sha256_round_stage_iter.sv - iterative multi-round SHA-256 compression stage
//
// Purpose:
//   Runs ROUNDS compression rounds, one per clock, starting at round index
//   ROUND_BASE, on the a..h state. Consumes one window word per round and
//   forwards the remaining window (shifted up, zero filled) with the state.
// Parameters:
//   ROUND_BASE  index of the first round done here (ROUND_BASE+ROUNDS <= 64)
//   ROUNDS      rounds per stage, 1..15
// Ports:
//   CLK        in   1    clock, rising edge
//   RST        in   1    asynchronous active-low reset
//   flush      in   1    synchronous abort of any job in flight
//   in_valid   in   1    upstream offers state_in/win_in
//   in_ready   out  1    stage accepts this cycle
//   state_in   in   256  {a..h}, a at [255:224]
//   win_in     in   480  W[t..t+14], W[t] at [479:448]
//   out_valid  out  1    state_out/win_out valid
//   out_ready  in   1    downstream accepts
//   state_out  out  256  state after ROUNDS rounds
//   win_out    out  480  win_in << (32*ROUNDS)

module sha256_round_stage_iter
  import sha256_pkg::*;
#(
  parameter int ROUND_BASE = 0,
  parameter int ROUNDS     = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] state_in,
  input  logic [479:0] win_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] state_out,
  output logic [479:0] win_out
);

  localparam int             CW   = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0]  LAST = CW'(ROUNDS - 1);

  stage_state_t  fsm, fsm_nxt;
  logic [CW-1:0] cnt;
  logic [255:0]  st_q;
  logic [479:0]  win_q;
  logic [255:0]  round_nxt;
  logic [5:0]    k_idx;
  logic          accept;

  // Round constant for the round currently being executed.
  assign k_idx = 6'(ROUND_BASE) + 6'(cnt);

  sha256_round_comb u_round (
    .cur (st_q),
    .w   (win_q[479:448]),
    .k   (K[k_idx]),
    .nxt (round_nxt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (fsm)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        // Retiring the result frees the stage in the same cycle, so a new
        // job can start without an idle bubble.
        in_ready  = out_ready;
      end
      default: ;
    endcase

    // A flush cycle never loads a job, even though in_ready may read high.
    accept = in_valid & in_ready & ~flush;

    case (fsm)
      IDLE: if (accept) fsm_nxt = RUN;
      RUN:  if (cnt == LAST) fsm_nxt = DONE;
      DONE: if (out_ready) fsm_nxt = accept ? RUN : IDLE;
      default: fsm_nxt = IDLE;
    endcase

    if (flush) fsm_nxt = IDLE;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      st_q  <= '0;
      win_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      st_q  <= state_in;
      win_q <= win_in;
    end else if (fsm == RUN && !flush) begin
      cnt   <= cnt + 1'b1;
      st_q  <= round_nxt;
      // The consumed word leaves the top; the next round's word moves into it.
      win_q <= {win_q[447:0], 32'h0};
    end
  end

  // Registers only change in RUN or on accept, so outputs hold while stalled.
  assign state_out = st_q;
  assign win_out   = win_q;

endmodule

// File: tb/tb_sha256_round_stage_iter.sv
// tb/tb_sha256_round_stage_iter.sv - scoreboard bench for sha256_round_stage_iter

module tb_sha256_round_stage_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [255:0] state_in, state_out;
  logic [479:0] win_in, win_out;

  logic         flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [255:0] state_in1, state_out1;
  logic [479:0] win_in1, win_out1;

  sha256_round_stage_iter #(.ROUND_BASE(0), .ROUNDS(3)) dut (
    .CLK(clk), .RST(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .win_in(win_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .win_out(win_out)
  );

  sha256_round_stage_iter #(.ROUND_BASE(0), .ROUNDS(1)) dut1 (
    .CLK(clk), .RST(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .state_in(state_in1), .win_in(win_in1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .state_out(state_out1), .win_out(win_out1)
  );

  typedef struct packed {
    logic [255:0] st;
    logic [479:0] win;
  } exp_t;

  localparam logic [255:0] IV_TB = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC3_ST = {
    32'hc8c347a7, 32'h5a6ad9ad, 32'h5d6aebcd, 32'h6a09e667,
    32'hf92939eb, 32'h78ce7989, 32'hfa2a4622, 32'h510e527f
  };
  localparam logic [255:0] ABC1_ST = {
    32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
    32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab
  };
  localparam logic [479:0] ABC_WIN = {32'h61626380, 448'h0};

  exp_t exp_q[$];
  exp_t exp1_q[$];
  int   out_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [479:0] act, input logic [479:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model written from the round equations.
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_round(input logic [255:0] s, input logic [31:0] w,
                                             input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic exp_t ref3(input logic [255:0] s, input logic [479:0] w);
    logic [31:0]  kk [3] = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf};
    logic [255:0] x;
    exp_t         r;
    x = s;
    for (int i = 0; i < 3; i++) x = ref_round(x, w[479-32*i -: 32], kk[i]);
    r.st  = x;
    r.win = w << 96;
    return r;
  endfunction

  function automatic logic [479:0] pat_win(input int j);
    logic [479:0] r;
    for (int i = 0; i < 15; i++) r[479-32*i -: 32] = 32'(32'h9e3779b9 * 32'(j * 16 + i + 1));
    return r;
  endfunction

  function automatic logic [255:0] pat_st(input int j);
    return IV_TB ^ {8{32'(32'h0f1e2d3c * 32'(j + 1))}};
  endfunction

  // Monitors: pop and compare whenever a result is handed downstream.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got state %0h expected no output", state_out);
      end else begin
        e = exp_q.pop_front();
        chk("state_out", 480'(state_out), 480'(e.st));
        chk("win_out", win_out, e.win);
        out_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output1: got state %0h expected no output", state_out1);
      end else begin
        e = exp1_q.pop_front();
        chk("state_out1", 480'(state_out1), 480'(e.st));
        chk("win_out1", win_out1, e.win);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic offer(input logic [255:0] s, input logic [479:0] w, input bit track,
                       input exp_t e, output int waited);
    bit ok;
    ok       = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    state_in = s;
    win_in   = w;
    while (!ok && waited < 40) begin
      @(negedge clk);
      if (in_ready && !flush) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout: got in_ready=0 for %0d cycles expected accept", waited);
    end else if (track) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int           lat, waited, prev;
    exp_t         ep, eq;
    logic [479:0] win1;

    rst_n = 1'b1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; state_in = '0; win_in = '0;
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; state_in1 = '0; win_in1 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 480'(out_valid), 480'(0));
    chk("rst_state", 480'(state_out), 480'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 480'(in_ready), 480'(1));
    chk("rel_out_valid", 480'(out_valid), 480'(0));
    chk("rel_win", win_out, 480'(0));

    // "abc" block, three rounds.
    offer(IV_TB, ABC_WIN, 1'b1, {ABC3_ST, 480'h0}, waited);
    wait_valid(lat);
    chk("abc_latency", 480'(lat), 480'(3));
    @(posedge clk);
    #1;
    chk("abc_idle_out_valid", 480'(out_valid), 480'(0));
    chk("abc_idle_in_ready", 480'(in_ready), 480'(1));

    // Single-round instance, with a populated window to see the shift.
    win1 = pat_win(7);
    win1[479:448] = 32'h61626380;
    in_valid1 = 1'b1;
    state_in1 = IV_TB;
    win_in1   = win1;
    @(negedge clk);
    chk("r1_in_ready", 480'(in_ready1), 480'(1));
    exp1_q.push_back({ABC1_ST, win1 << 32});
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    chk("r1_latency_valid", 480'(out_valid1), 480'(0));
    @(posedge clk);
    #1;
    chk("r1_out_valid", 480'(out_valid1), 480'(1));
    @(posedge clk);
    #1;
    chk("r1_idle", 480'(out_valid1), 480'(0));

    // Backpressure: result must hold while downstream stalls.
    out_ready = 1'b0;
    ep = ref3(pat_st(1), pat_win(1));
    offer(pat_st(1), pat_win(1), 1'b1, ep, waited);
    wait_valid(lat);
    chk("bp_latency", 480'(lat), 480'(3));
    for (int i = 0; i < 5; i++) begin
      chk("bp_state_hold", 480'(state_out), 480'(ep.st));
      chk("bp_win_hold", win_out, ep.win);
      chk("bp_in_ready", 480'(in_ready), 480'(0));
      chk("bp_out_valid", 480'(out_valid), 480'(1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    eq = ref3(pat_st(2), pat_win(2));
    offer(pat_st(2), pat_win(2), 1'b1, eq, waited);
    chk("bp_accept_same_cycle", 480'(waited), 480'(0));
    chk("bp_out_valid_drop", 480'(out_valid), 480'(0));
    wait_valid(lat);
    chk("bp_next_latency", 480'(lat), 480'(3));
    @(posedge clk);
    #1;

    // Back-to-back stream: each DONE cycle also accepts the next job, so a
    // result appears every ROUNDS+1 cycles.
    out_cyc.delete();
    for (int j = 3; j < 7; j++) offer(pat_st(j), pat_win(j), 1'b1, ref3(pat_st(j), pat_win(j)), waited);
    wait_valid(lat);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_count", 480'(out_cyc.size()), 480'(4));
    if (out_cyc.size() == 4) begin
      prev = out_cyc[0];
      for (int i = 1; i < 4; i++) begin
        chk("stream_spacing", 480'(out_cyc[i] - prev), 480'(4));
        prev = out_cyc[i];
      end
    end

    // flush in the same cycle as an offer: the job must not be taken.
    flush    = 1'b1;
    in_valid = 1'b1;
    state_in = pat_st(10);
    win_in   = pat_win(10);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("flush_drop_in_ready", 480'(in_ready), 480'(1));

    // flush in RUN at cnt=1: aborted result must never reach the monitor.
    offer(pat_st(8), pat_win(8), 1'b0, '0, waited);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_out_valid", 480'(out_valid), 480'(0));
    chk("flush_in_ready", 480'(in_ready), 480'(1));
    repeat (5) @(posedge clk);
    #1;

    // Asynchronous reset between edges in the middle of a job.
    offer(pat_st(9), pat_win(9), 1'b0, '0, waited);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 480'(out_valid), 480'(0));
    chk("arst_state", 480'(state_out), 480'(0));
    chk("arst_win", win_out, 480'(0));
    chk("arst_in_ready", 480'(in_ready), 480'(1));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    offer(IV_TB, ABC_WIN, 1'b1, {ABC3_ST, 480'h0}, waited);
    wait_valid(lat);
    chk("post_rst_latency", 480'(lat), 480'(3));

    repeat (3) @(posedge clk);
    #1;
    chk("drain", 480'(exp_q.size()), 480'(0));
    chk("drain1", 480'(exp1_q.size()), 480'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
